cordic_gain_scale_pipe: RTL and testbench
=========================================

// Module: cordic_gain_scale_pipe
// PURPOSE
//  Pipelined, multi-channel CORDIC gain compensation. Multiplies each signed lane by a
//  mode-selected constant: 1/K circular, 1/K' hyperbolic, unity bypass, or zero.
//  Rounds and saturates each lane. Sits between the CORDIC iteration core and downstream
//  consumers. Uses a valid/ready stream with a global stall, one beat per cycle.
// PARAMETERS
//  CORDIC_WIDTH  22       lane width, signed two's complement
//  NUM_CH        2        lanes per beat (e.g. x,y), packed lane0 in LSBs
//  TAG_WIDTH     4        sideband tag carried unchanged alongside data
//  COEF_CIRC     17'h04DBA  circular scale, unsigned Q2.15 (0.607253)
//  COEF_HYP      17'h09A8F  hyperbolic scale, unsigned Q2.15 (1.207497)
// PORTS
//  clk        in   1                  clock
//  rst        in   1                  synchronous reset, active-high
//  in_valid   in   1                  input beat valid
//  in_ready   out  1                  block accepts beat this cycle
//  in_mode    in   2                  00 zero, 01 circular, 10 hyperbolic, 11 bypass
//  in_data    in   NUM_CH*CORDIC_WIDTH  signed lanes
//  in_tag     in   TAG_WIDTH          sideband tag
//  out_valid  out  1                  output beat valid
//  out_ready  in   1                  downstream accepts beat
//  out_data   out  NUM_CH*CORDIC_WIDTH  scaled lanes
//  out_tag    out  TAG_WIDTH          tag of the beat in out_data
//  out_sat    out  1                  one or more lanes of this beat saturated
// BEHAVIOUR
//  - One clock domain. Reset is synchronous and active-high.
//  - Reset values: all stage valids=0, out_valid=0, out_data=0, out_tag=0, out_sat=0.
//  - Pipeline stages:
//    - S1 registers data, mode and tag.
//    - S2 registers the full product, CORDIC_WIDTH+18 bits signed.
//    - S3 rounds and saturates into the output register.
//  - stall = out_valid & ~out_ready. When stall=1, every stage holds. Otherwise all
//    stages advance.
//  - in_ready = ~stall, combinational. A beat transfers when in_valid & in_ready.
//    A cycle with no transfer inserts a bubble (valid=0).
//  - Latency: 3 cycles from input transfer to out_valid with no stall. Throughput:
//    1 beat/cycle. Beat order and tag pairing are preserved.
//  - Data, mode and tag of a stalled beat stay stable until the beat transfers.
//  - Mode is per-beat. Beats with different modes may be back-to-back.
//  - Coefficient by mode: 00 -> 0; 01 -> COEF_CIRC; 10 -> COEF_HYP; 11 -> 2^15 (exact).
//  - Product p = lane * coef (signed x unsigned), computed at full width.
//  - Rounding: r = (p + 2^14) >>> 15, arithmetic shift, round-half-up.
//  - Saturation: r > 2^(W-1)-1 gives 2^(W-1)-1; r < -2^(W-1) gives -2^(W-1).
//    Either case flags that lane. out_sat is the OR over lanes, valid only with
//    out_valid.
//  - Circular, bypass and zero modes never saturate. Only hyperbolic can.
//  - out_data and out_tag update only on stage advance. Bubbles clear out_sat. Data
//    of a bubble is don't-care but must not be X after reset.
//  - rst asserted mid-stream: all in-flight beats are dropped and no partial beat is
//    emitted. in_ready=1 in the first cycle after reset.
//  - Simultaneous output transfer and input transfer in the same cycle is legal and
//    required for full throughput.
// TESTING
//  (defaults, lane0 shown, lane1 = -lane0 unless stated)
//  1. Circular scaling: lane0=1048576, mode 01, out_ready=1
//     -> 3 cycles later out_data lane0=636736, lane1=-636736, out_sat=0.
//  2. Hyperbolic scaling and saturation:
//     - lane0=1048576, mode 10 -> lane0=1266144, out_sat=0.
//     - lane0=2000000, mode 10 -> lane0=2097151, lane1=-2097152, out_sat=1.
//  3. Rounding and mode mix: lane0=1 then -1 (mode 01), then 12345 (mode 11), then
//     777 (mode 00) back-to-back -> outputs 1, -1, 12345, 0 on consecutive cycles,
//     tags in order.
//  4. Backpressure: stream 8 beats with random in_valid while out_ready toggles
//     1,0,0,1...
//     - in_ready equals ~(out_valid & ~out_ready) every cycle.
//     - No beat is lost or duplicated; held out_data/out_tag are stable during stall.
//     - Scoreboard matches the reference model.
//  5. Reset mid-operation: assert rst for 1 cycle with 3 beats in flight and
//     out_ready=0 -> next cycle out_valid=0, out_data=0, out_sat=0, in_ready=1. No
//     pre-reset beat appears afterwards.
//  6. Random regression: 10k beats, random modes, lanes, tags and out_ready ->
//     bit-exact against the model, including out_sat.

Source files
------------

// File: rtl/cordic_gain_scale_pipe.sv
// Purpose: per-lane CORDIC gain compensation (zero / 1/K / 1/K' / unity) with round-half-up and saturation.
// Latency: 3 cycles input transfer to out_valid, 1 beat/cycle throughput.
// Backpressure: global stall (out_valid & ~out_ready) freezes every stage; in_ready = ~stall.
module cordic_gain_scale_pipe #(
    parameter int          CORDIC_WIDTH = 22,
    parameter int          NUM_CH       = 2,
    parameter int          TAG_WIDTH    = 4,
    parameter logic [16:0] COEF_CIRC    = 17'h04DBA,
    parameter logic [16:0] COEF_HYP     = 17'h09A8F
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [1:0]                     in_mode,
    input  logic [NUM_CH*CORDIC_WIDTH-1:0] in_data,
    input  logic [TAG_WIDTH-1:0]           in_tag,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_CH*CORDIC_WIDTH-1:0] out_data,
    output logic [TAG_WIDTH-1:0]           out_tag,
    output logic                           out_sat
);

    localparam int W  = CORDIC_WIDTH;
    localparam int PW = CORDIC_WIDTH + 18;
    localparam int RW = PW - 15 + 1;

    localparam logic [1:0] MODE_ZERO = 2'b00;
    localparam logic [1:0] MODE_CIRC = 2'b01;
    localparam logic [1:0] MODE_HYP  = 2'b10;
    localparam logic [1:0] MODE_BYP  = 2'b11;

    localparam logic [16:0] COEF_UNITY = 17'h08000;

    logic stall;
    logic adv;

    assign stall    = out_valid & ~out_ready;
    assign adv      = ~stall;
    assign in_ready = adv;

    logic                      s1_valid;
    logic [NUM_CH*W-1:0]       s1_data;
    logic [1:0]                s1_mode;
    logic [TAG_WIDTH-1:0]      s1_tag;

    logic                      s2_valid;
    logic [NUM_CH*PW-1:0]      s2_prod;
    logic [TAG_WIDTH-1:0]      s2_tag;

    logic [16:0]               s1_coef;
    logic [NUM_CH*PW-1:0]      prod_nxt;
    logic [NUM_CH*W-1:0]       res_nxt;
    logic [NUM_CH-1:0]         sat_lane;

    always_comb begin
        s1_coef = '0;
        case (s1_mode)
            MODE_ZERO: s1_coef = '0;
            MODE_CIRC: s1_coef = COEF_CIRC;
            MODE_HYP:  s1_coef = COEF_HYP;
            MODE_BYP:  s1_coef = COEF_UNITY;
            default:   s1_coef = '0;
        endcase
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        logic [W-1:0]  lane;
        logic [PW-1:0] lane_ext;
        logic [PW-1:0] coef_ext;
        logic [PW-1:0] p2;
        logic [RW-1:0] r;
        logic          ovf;
        logic          unused_lo;

        assign lane     = s1_data[i*W +: W];
        assign lane_ext = {{(PW-W){lane[W-1]}}, lane};
        assign coef_ext = {{(PW-17){1'b0}}, s1_coef};
        // Low PW bits of the unsigned product equal the two's complement signed product.
        assign prod_nxt[i*PW +: PW] = lane_ext * coef_ext;

        // (p + 2^14) >>> 15 == floor(p / 2^15) + p[14]
        assign p2        = s2_prod[i*PW +: PW];
        assign r         = {p2[PW-1], p2[PW-1:15]} + {{(RW-1){1'b0}}, p2[14]};
        assign unused_lo = ^p2[13:0];

        assign ovf = ~((&r[RW-1:W-1]) | ~(|r[RW-1:W-1]));
        assign sat_lane[i] = ovf;
        assign res_nxt[i*W +: W] = ovf ? (r[RW-1] ? {1'b1, {(W-1){1'b0}}}
                                                  : {1'b0, {(W-1){1'b1}}})
                                       : r[W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_mode   <= MODE_ZERO;
            s1_tag    <= '0;
            s2_valid  <= 1'b0;
            s2_prod   <= '0;
            s2_tag    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
            out_sat   <= 1'b0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s1_data   <= in_data;
            s1_mode   <= in_mode;
            s1_tag    <= in_tag;
            s2_valid  <= s1_valid;
            s2_prod   <= prod_nxt;
            s2_tag    <= s1_tag;
            out_valid <= s2_valid;
            out_data  <= res_nxt;
            out_tag   <= s2_tag;
            out_sat   <= s2_valid & (|sat_lane);
        end
    end

endmodule

// File: tb/tb_cordic_gain_scale_pipe.sv
// Directed and scoreboarded bench for cordic_gain_scale_pipe (W=22, 2 lanes, 4-bit tag).
module tb_cordic_gain_scale_pipe;

    localparam int W  = 22;
    localparam int NC = 2;
    localparam int TW = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         in_mode;
    logic [NC*W-1:0]    in_data;
    logic [TW-1:0]      in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [NC*W-1:0]    out_data;
    logic [TW-1:0]      out_tag;
    logic               out_sat;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [NC*W-1:0] data;
        logic [TW-1:0]   tag;
        logic            sat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    cordic_gain_scale_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_sat   (out_sat)
    );

    function automatic logic [NC*W-1:0] pk(input int a, input int b);
        logic [31:0] av, bv;
        av = a;
        bv = b;
        return {bv[W-1:0], av[W-1:0]};
    endfunction

    function automatic logic [W-1:0] model_lane(input logic [W-1:0] x, input logic [1:0] m,
                                                 output logic s);
        longint xs, c, p, r;
        logic signed [W-1:0] xv;
        xv = x;
        xs = xv;
        case (m)
            2'b00:   c = 0;
            2'b01:   c = 19898;
            2'b10:   c = 39567;
            default: c = 32768;
        endcase
        p = xs * c;
        r = (p + 16384) >>> 15;
        s = 1'b0;
        if (r > 2097151) begin
            r = 2097151;
            s = 1'b1;
        end else if (r < -2097152) begin
            r = -2097152;
            s = 1'b1;
        end
        return r[W-1:0];
    endfunction

    function automatic exp_t model_beat(input logic [NC*W-1:0] d, input logic [1:0] m,
                                        input logic [TW-1:0] t);
        exp_t e;
        logic s0, s1;
        e.data[W-1:0]   = model_lane(d[W-1:0], m, s0);
        e.data[2*W-1:W] = model_lane(d[2*W-1:W], m, s1);
        e.tag = t;
        e.sat = s0 | s1;
        return e;
    endfunction

    function automatic logic [W-1:0] rand_lane();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'h0020_0000;
            1:       v = 32'h001F_FFFF;
            default: v = $urandom;
        endcase
        return v[W-1:0];
    endfunction

    task automatic idle(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_tag !== '0 || out_sat !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: valid=%b data=%h tag=%h sat=%b, required 0/0/0/0",
                     out_valid, out_data, out_tag, out_sat);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_circular();
        idle(4);
        for (int c = 0; c < 4; c++) begin
            if (c == 0) begin
                in_valid = 1'b1;
                in_data  = pk(1048576, -1048576);
                in_mode  = 2'b01;
                in_tag   = 4'h5;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (c < 3) begin
                n_cmp++;
                if (out_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL circ_latency: out_valid=%b at cycle %0d, required 0", out_valid, c);
                end
            end else begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== pk(636736, -636736) ||
                    out_tag !== 4'h5 || out_sat !== 1'b0) begin
                    n_bad++;
                    $display("FAIL circ_value: valid=%b data=%h tag=%h sat=%b, required 1 %h 5 0",
                             out_valid, out_data, out_tag, out_sat, pk(636736, -636736));
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_hyperbolic();
        logic [NC*W-1:0] ed [2];
        logic            es [2];
        ed[0] = pk(1266144, -1266144);  es[0] = 1'b0;
        ed[1] = pk(2097151, -2097152);  es[1] = 1'b1;
        idle(4);
        for (int c = 0; c < 6; c++) begin
            in_valid = (c < 2);
            in_data  = (c == 0) ? pk(1048576, -1048576) : pk(2000000, -2000000);
            in_mode  = 2'b10;
            in_tag   = 4'(c + 2);
            @(negedge clk);
            if (c == 3 || c == 4) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== ed[c-3] || out_tag !== 4'(c - 1) ||
                    out_sat !== es[c-3]) begin
                    n_bad++;
                    $display("FAIL hyp_beat%0d: valid=%b data=%h tag=%h sat=%b, required 1 %h %h %b",
                             c - 3, out_valid, out_data, out_tag, out_sat, ed[c-3], 4'(c - 1), es[c-3]);
                end
            end else if (c == 5) begin
                n_cmp++;
                if (out_valid !== 1'b0 || out_sat !== 1'b0) begin
                    n_bad++;
                    $display("FAIL hyp_bubble_sat: valid=%b sat=%b, required 0 0", out_valid, out_sat);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_rounding_mix();
        int         l0 [4] = '{1, -1, 12345, 777};
        logic [1:0] md [4] = '{2'b01, 2'b01, 2'b11, 2'b00};
        int         ex [4] = '{1, -1, 12345, 0};
        idle(4);
        for (int c = 0; c < 7; c++) begin
            in_valid = (c < 4);
            if (c < 4) begin
                in_data = pk(l0[c], -l0[c]);
                in_mode = md[c];
                in_tag  = 4'(c + 9);
            end
            @(negedge clk);
            if (c >= 3) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== pk(ex[c-3], -ex[c-3]) ||
                    out_tag !== 4'(c + 6) || out_sat !== 1'b0) begin
                    n_bad++;
                    $display("FAIL mix_beat%0d: valid=%b data=%h tag=%h sat=%b, required 1 %h %h 0",
                             c - 3, out_valid, out_data, out_tag, out_sat,
                             pk(ex[c-3], -ex[c-3]), 4'(c + 6));
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_backpressure();
        int              sent = 0, got = 0, cyc = 0;
        bit              have = 0, prev_stall = 0;
        logic [NC*W-1:0] d = '0, hd = '0;
        logic [1:0]      m = '0;
        logic [TW-1:0]   t = '0, ht = '0;
        exp_t            e;
        idle(4);
        sb.delete();
        while (got < 8 && cyc < 200) begin
            if (!have && sent < 8 && $urandom_range(0, 1) == 1) begin
                d = {rand_lane(), rand_lane()};
                m = 2'($urandom_range(0, 3));
                t = 4'(sent + 3);
                have = 1;
            end
            in_valid  = have;
            in_data   = d;
            in_mode   = m;
            in_tag    = t;
            out_ready = (cyc % 3 == 0);
            @(negedge clk);
            n_cmp++;
            if (in_ready !== ~(out_valid & ~out_ready)) begin
                n_bad++;
                $display("FAIL bp_in_ready: got %b with out_valid=%b out_ready=%b", in_ready,
                         out_valid, out_ready);
            end
            if (prev_stall) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== hd || out_tag !== ht) begin
                    n_bad++;
                    $display("FAIL bp_hold: valid=%b data=%h tag=%h, required 1 %h %h",
                             out_valid, out_data, out_tag, hd, ht);
                end
            end
            prev_stall = out_valid & ~out_ready;
            hd = out_data;
            ht = out_tag;
            if (out_valid && out_ready) begin
                got++;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL bp_extra_beat: tag=%h with empty scoreboard", out_tag);
                end else begin
                    e = sb.pop_front();
                    if (out_data !== e.data || out_tag !== e.tag || out_sat !== e.sat) begin
                        n_bad++;
                        $display("FAIL bp_beat: data=%h tag=%h sat=%b, required %h %h %b",
                                 out_data, out_tag, out_sat, e.data, e.tag, e.sat);
                    end
                end
            end
            if (have && in_ready) begin
                sb.push_back(model_beat(d, m, t));
                have = 0;
                sent++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (got != 8 || sb.size() != 0) begin
            n_bad++;
            $display("FAIL bp_count: received %0d with %0d pending, required 8 and 0", got, sb.size());
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        idle(4);
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid = (c < 3);
            in_data  = (c == 0) ? pk(2000000, 5) : pk(100 * c, -7);
            in_mode  = (c == 0) ? 2'b10 : 2'b01;
            in_tag   = 4'(c + 1);
            @(negedge clk);
            if (c == 3) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_sat !== 1'b1) begin
                    n_bad++;
                    $display("FAIL rstmid_pre: valid=%b sat=%b, required 1 1", out_valid, out_sat);
                end
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_sat !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_post: valid=%b data=%h sat=%b in_ready=%b, required 0 0 0 1",
                     out_valid, out_data, out_sat, in_ready);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL rstmid_ghost: %0d beats after reset, required 0", seen);
        end
    endtask

    task automatic test_random();
        int              sent = 0, got = 0, cyc = 0;
        bit              have = 0;
        logic [NC*W-1:0] d = '0;
        logic [1:0]      m = '0;
        logic [TW-1:0]   t = '0;
        exp_t            e;
        int              nsat = 0;
        idle(4);
        sb.delete();
        while (got < 10000 && cyc < 60000) begin
            if (!have && sent < 10000 && $urandom_range(0, 3) != 0) begin
                d = {rand_lane(), rand_lane()};
                m = 2'($urandom_range(0, 3));
                t = 4'($urandom);
                have = 1;
            end
            in_valid  = have;
            in_data   = d;
            in_mode   = m;
            in_tag    = t;
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (out_valid && out_ready) begin
                got++;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL rand_extra_beat: tag=%h with empty scoreboard", out_tag);
                end else begin
                    e = sb.pop_front();
                    if (e.sat) nsat++;
                    if (out_data !== e.data || out_tag !== e.tag || out_sat !== e.sat) begin
                        n_bad++;
                        $display("FAIL rand_beat%0d: data=%h tag=%h sat=%b, required %h %h %b",
                                 got, out_data, out_tag, out_sat, e.data, e.tag, e.sat);
                    end
                end
            end
            if (have && in_ready) begin
                sb.push_back(model_beat(d, m, t));
                have = 0;
                sent++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (got != 10000 || sb.size() != 0) begin
            n_bad++;
            $display("FAIL rand_count: received %0d with %0d pending, required 10000 and 0",
                     got, sb.size());
        end
        n_cmp++;
        if (nsat == 0) begin
            n_bad++;
            $display("FAIL rand_sat_coverage: saturating beats seen %0d, required > 0", nsat);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mode   = 2'b00;
        in_data   = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        test_reset();
        test_circular();
        test_hyperbolic();
        test_rounding_mix();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
